// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared encodings and segment constants for the result animator
package anim_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_WIN  = 2'd1,
    MODE_LOSE = 2'd2,
    MODE_SPIN = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_TOP   = 8'hFE;
  localparam logic [7:0] SEG_BOT   = 8'hF7;
  localparam logic [7:0] SEG_BOTH  = 8'hF6;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Spin walks segments a..f, so its index wraps after 5
  localparam logic [2:0] SPIN_LAST = 3'd5;

endpackage

// File: rtl/frame_ticker.sv
// rtl/frame_ticker.sv - frame-rate divider producing one tick per TICK_DIV cycles
module frame_ticker #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  output logic tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  // Tick on the last count of each frame; never while stopped
  assign tick = run && (div_q == DIV_LAST);

  // Count while running and wrap at the frame boundary; hold at zero otherwise
  always_comb begin
    div_d = '0;
    if (run) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // Divider register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/result_animator.sv
// rtl/result_animator.sv - end-of-game 7-segment animation controller
module result_animator
  import anim_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 25000000,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    clear,
  output logic [8*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    done
);

  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);

  state_t                  state_q, state_d;
  mode_t                   mode_q, mode_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic [2:0]              spin_q, spin_d;
  logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    run;
  logic                    tick;

  // clear stops the divider in the same cycle so counters are zero next cycle
  assign run = (state_q == RUN) && !clear;

  frame_ticker #(
    .TICK_DIV(TICK_DIV)
  ) u_ticker (
    .clock (clock),
    .resetn(resetn),
    .run   (run),
    .tick  (tick)
  );

  // Display pattern for a given state/mode/frame; even and odd digits may differ
  function automatic logic [8*NUM_DIGITS-1:0] pattern(input state_t st, input mode_t md,
                                                      input logic parity, input logic [2:0] idx);
    logic [8*NUM_DIGITS-1:0] p;
    logic [7:0]              even_seg;
    logic [7:0]              odd_seg;
    even_seg = SEG_BLANK;
    odd_seg  = SEG_BLANK;
    p        = '1;
    case (st)
      RUN: begin
        case (md)
          MODE_WIN: begin
            even_seg = parity ? SEG_BOT : SEG_TOP;
            odd_seg  = parity ? SEG_TOP : SEG_BOT;
          end
          MODE_LOSE: begin
            even_seg = parity ? SEG_BLANK : SEG_DASH;
            odd_seg  = even_seg;
          end
          MODE_SPIN: begin
            even_seg = ~(8'h01 << idx);
            odd_seg  = even_seg;
          end
          default: ;
        endcase
      end
      HOLD: begin
        case (md)
          MODE_WIN:  even_seg = SEG_BOTH;
          MODE_LOSE: even_seg = SEG_DASH;
          default:   even_seg = SEG_BLANK;
        endcase
        odd_seg = even_seg;
      end
      default: ;
    endcase
    for (int k = 0; k < NUM_DIGITS; k++) begin
      p[8*k +: 8] = (k % 2 == 0) ? even_seg : odd_seg;
    end
    return p;
  endfunction

  // Next-state logic; the display is computed from next-state values so it is registered
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    frame_d = frame_q;
    spin_d  = spin_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      frame_d = '0;
      spin_d  = '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (start && (mode != MODE_NONE)) begin
            state_d = RUN;
            mode_d  = mode_t'(mode);
            frame_d = '0;
            spin_d  = '0;
          end
        end
        RUN: begin
          if (tick) begin
            if (frame_q == FRAME_LAST) begin
              state_d = HOLD;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_q + 1'b1;
              spin_d  = (spin_q == SPIN_LAST) ? 3'd0 : spin_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    hex_d  = pattern(state_d, mode_d, frame_d[0], spin_d);
  end

  // State and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mode_q  <= MODE_NONE;
      frame_q <= '0;
      spin_q  <= '0;
      hex_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      frame_q <= frame_d;
      spin_q  <= spin_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign hex_out = hex_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
